mem_access_sequencer: RTL

- Sequences one CPU load/store at a time onto the single-port memory bus.
- Accepts a request (opcode, effective address, rt value) from the execute stage and checks alignment.
- Drives word-aligned address, byteenable and lane-shifted writedata, honours waitrequest, then merges/extends read data and returns one response.
- Sits between the core datapath and the memory bus; the core stalls while req_ready is low.

---
 rtl/mem_access_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// mem_access_sequencer: runs one CPU load/store at a time on a single-port memory bus (rev 1.0).
// It checks alignment, sets the byte lanes, handles waitrequest with a watchdog, and merges load data.
module mem_access_sequencer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rt,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]       state, state_next;
  logic [5:0]       lat_op;
  logic [1:0]       lat_k;
  logic [31:0]      lat_rt;
  logic [CNT_W-1:0] wd_cnt;
  logic             req_bad, lat_store, timeout;
  logic [5:0]       sh_lo;
  logic [31:0]      shifted, load_result;

  function automatic logic op_known(input logic [5:0] op);
    logic known;
    known = 1'b0;
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [5:0] op, input logic [1:0] k);
    logic [3:0] m;
    m = 4'b1111;
    case (op)
      OP_LB, OP_LBU, OP_SB: m = 4'b0001 << k;
      OP_LH, OP_LHU, OP_SH: m = k[1] ? 4'b1100 : 4'b0011;
      OP_LWL:               m = 4'b1111 >> (2'd3 - k);
      OP_LWR:               m = 4'b1111 << k;
      default:              m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] rt);
    logic [31:0] d;
    d = rt;
    case (op)
      OP_SB:   d = {4{rt[7:0]}};
      OP_SH:   d = {2{rt[15:0]}};
      default: d = rt;
    endcase
    return d;
  endfunction

  assign req_bad = !op_known(req_opcode)
                 || ((req_opcode == OP_LH || req_opcode == OP_LHU || req_opcode == OP_SH) && req_addr[0])
                 || ((req_opcode == OP_LW || req_opcode == OP_SW) && (req_addr[1:0] != 2'b00));

  // Every store opcode has bit 3 set, and no load opcode does.
  assign lat_store = lat_op[3];
  assign timeout   = (WAIT_LIMIT != 0) && waitrequest && ((int'(wd_cnt) + 1) == WAIT_LIMIT);

  assign sh_lo   = {1'b0, lat_k, 3'b000};
  assign shifted = readdata >> sh_lo;

  always_comb begin
    load_result = readdata;
    case (lat_op)
      OP_LB:   load_result = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_result = {24'd0, shifted[7:0]};
      OP_LH:   load_result = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_result = {16'd0, shifted[15:0]};
      OP_LWL:  load_result = (readdata << (6'd24 - sh_lo)) | (lat_rt & (32'hFFFF_FFFF >> (sh_lo + 6'd8)));
      OP_LWR:  load_result = shifted | (lat_rt & ~(32'hFFFF_FFFF >> sh_lo));
      default: load_result = readdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = req_bad ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (!waitrequest || timeout) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE:   req_ready = 1'b1;
      ST_ACCESS: begin
        read  = !lat_store;
        write = lat_store;
      end
      ST_RESP:   resp_valid = 1'b1;
      default:   req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_op     <= '0;
      lat_k      <= '0;
      lat_rt     <= '0;
      wd_cnt     <= '0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_op <= req_opcode;
            lat_k  <= req_addr[1:0];
            lat_rt <= req_rt;
            wd_cnt <= '0;
            if (req_bad) begin
              resp_data <= '0;
              resp_err  <= 1'b1;
            end else begin
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= lane_mask(req_opcode, req_addr[1:0]);
              writedata  <= store_data(req_opcode, req_rt);
            end
          end
        end
        ST_ACCESS: begin
          if (!waitrequest) begin
            resp_data <= lat_store ? 32'd0 : load_result;
            resp_err  <= 1'b0;
          end else if (timeout) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: wd_cnt <= wd_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire
